hazard_scoreboard: RTL and testbench

//  Parametrised data-hazard unit for the in-order pipeline. Tracks in-flight register writes across the

---
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_hazard_scoreboard.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit: tracks in-flight writers over DEPTH stages, resolves forwarding selects and ID stalls.
// Latency: stall_id, selects and pending_mask are combinational; entries and stall_count update on the clock edge.
// Backpressure: stall_ext freezes every entry and the counter; a hazard holds ID and injects a bubble into EX.
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 4,
   parameter int DEPTH      = 4,
   parameter int ALU_STAGE  = 1,
   parameter int LOAD_STAGE = 3,
   parameter bit FWD_EN     = 1'b1,
   parameter int CNT_W      = 16,
   localparam int NUM_REGS  = 2**REG_ADDR_W,
   localparam int SEL_W     = $clog2(DEPTH+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_we,
   input  logic                  id_is_load,
   input  logic                  flush,
   input  logic                  stall_ext,
   output logic                  stall_id,
   output logic [SEL_W-1:0]      fwd_rs1_sel,
   output logic [SEL_W-1:0]      fwd_rs2_sel,
   output logic [NUM_REGS-1:0]   pending_mask,
   output logic [CNT_W-1:0]      stall_count
);

   typedef struct packed {
      logic                  vld;
      logic [REG_ADDR_W-1:0] rd;
      logic                  is_load;
   } entry_t;

   entry_t                entry_q [DEPTH];
   entry_t                new_entry;
   logic [REG_ADDR_W-1:0] src_idx [2];
   logic                  src_use [2];
   logic                  match_vld [2];
   logic [SEL_W-1:0]      match_k [2];
   logic                  match_ld [2];
   logic [SEL_W-1:0]      src_sel [2];
   logic                  src_haz [2];
   logic                  hazard;
   logic                  issue;

   always_comb begin
      src_idx[0] = id_rs1;
      src_idx[1] = id_rs2;
      src_use[0] = id_uses_rs1;
      src_use[1] = id_uses_rs2;
   end

   // Scan oldest to youngest so the youngest matching writer is the one left standing.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         match_vld[s] = 1'b0;
         match_k[s]   = '0;
         match_ld[s]  = 1'b0;
         src_sel[s]   = '0;
         src_haz[s]   = 1'b0;
         for (int k = DEPTH-1; k >= 0; k--) begin
            if (entry_q[k].vld && entry_q[k].rd == src_idx[s]) begin
               match_vld[s] = 1'b1;
               match_k[s]   = SEL_W'(k);
               match_ld[s]  = entry_q[k].is_load;
            end
         end
         if (src_use[s] && src_idx[s] != '0 && match_vld[s]) begin
            if (FWD_EN && match_k[s] >= (match_ld[s] ? SEL_W'(LOAD_STAGE) : SEL_W'(ALU_STAGE)))
               src_sel[s] = match_k[s] + SEL_W'(1);
            else
               src_haz[s] = 1'b1;
         end
      end
   end

   always_comb begin
      hazard          = id_valid & ~flush & (src_haz[0] | src_haz[1]);
      issue           = id_valid & ~flush & ~hazard & ~stall_ext;
      stall_id        = hazard | stall_ext;
      fwd_rs1_sel     = src_sel[0];
      fwd_rs2_sel     = src_sel[1];
      new_entry.vld   = issue & id_we & (id_rd != '0);
      new_entry.rd    = new_entry.vld ? id_rd : '0;
      new_entry.is_load = new_entry.vld & id_is_load;
   end

   always_comb begin
      pending_mask = '0;
      for (int k = 0; k < DEPTH; k++)
         if (entry_q[k].vld) pending_mask[entry_q[k].rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) entry_q[k] <= '0;
         stall_count <= '0;
      end else if (!stall_ext) begin
         entry_q[0] <= new_entry;
         for (int k = 1; k < DEPTH; k++) entry_q[k] <= entry_q[k-1];
         if (hazard && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: instance A (forwarding, 16-bit counter) and B (no forwarding, 2-bit counter) share stimulus.
// A queue-based writer model checks both every cycle; directed vectors pin hand-computed values.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [3:0] id_rs1, id_rs2, id_rd;
   logic       id_uses_rs1, id_uses_rs2, id_we, id_is_load;
   logic       flush, stall_ext;

   logic        a_stall_id, b_stall_id;
   logic [2:0]  a_sel1, a_sel2, b_sel1, b_sel2;
   logic [15:0] a_mask, b_mask;
   logic [15:0] a_cnt;
   logic [1:0]  b_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard u_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_we(id_we),
      .id_is_load(id_is_load), .flush(flush), .stall_ext(stall_ext), .stall_id(a_stall_id),
      .fwd_rs1_sel(a_sel1), .fwd_rs2_sel(a_sel2), .pending_mask(a_mask), .stall_count(a_cnt)
   );

   hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_we(id_we),
      .id_is_load(id_is_load), .flush(flush), .stall_ext(stall_ext), .stall_id(b_stall_id),
      .fwd_rs1_sel(b_sel1), .fwd_rs2_sel(b_sel2), .pending_mask(b_mask), .stall_count(b_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Model: each in-flight writer carries the stage it currently occupies.
   typedef struct {
      int         stage;
      logic [3:0] rd;
      bit         ld;
   } wr_t;

   wr_t mq [2][$];
   int  mcnt [2];
   bit  started = 1'b0;

   function automatic void lookup(input int inst, input logic [3:0] s, input logic used,
                                  output int sel, output bit haz);
      int best = -1;
      sel = 0;
      haz = 1'b0;
      if (!used || s == 4'd0) return;
      for (int i = 0; i < mq[inst].size(); i++)
         if (mq[inst][i].rd == s && (best < 0 || mq[inst][i].stage < mq[inst][best].stage)) best = i;
      if (best < 0) return;
      if (inst == 0 && mq[inst][best].stage >= (mq[inst][best].ld ? 3 : 1))
         sel = mq[inst][best].stage + 1;
      else
         haz = 1'b1;
   endfunction

   function automatic bit model_hazard(input int inst);
      int  s1, s2;
      bit  h1, h2;
      lookup(inst, id_rs1, id_uses_rs1, s1, h1);
      lookup(inst, id_rs2, id_uses_rs2, s2, h2);
      return id_valid && !flush && (h1 || h2);
   endfunction

   function automatic int model_mask(input int inst);
      int m = 0;
      for (int i = 0; i < mq[inst].size(); i++) m |= (1 << mq[inst][i].rd);
      return m;
   endfunction

   always @(posedge clk) begin
      bit h;
      int cmax;
      if (rst) begin
         mq[0].delete();
         mq[1].delete();
         mcnt[0] = 0;
         mcnt[1] = 0;
         started = 1'b1;
      end else if (!stall_ext) begin
         for (int inst = 0; inst < 2; inst++) begin
            h    = model_hazard(inst);
            cmax = (inst == 0) ? 65535 : 3;
            if (h && mcnt[inst] < cmax) mcnt[inst]++;
            for (int i = 0; i < mq[inst].size(); i++) mq[inst][i].stage++;
            for (int i = mq[inst].size() - 1; i >= 0; i--)
               if (mq[inst][i].stage >= 4) mq[inst].delete(i);
            if (id_valid && !flush && !h && id_we && id_rd != 4'd0)
               mq[inst].push_back('{0, id_rd, id_is_load});
         end
      end
   end

   always @(negedge clk) begin
      int s1, s2;
      bit h1, h2;
      int exp_stall;
      if (started) begin
         for (int inst = 0; inst < 2; inst++) begin
            lookup(inst, id_rs1, id_uses_rs1, s1, h1);
            lookup(inst, id_rs2, id_uses_rs2, s2, h2);
            exp_stall = ((id_valid && !flush && (h1 || h2)) || stall_ext) ? 1 : 0;
            chk(inst == 0 ? "model A stall_id" : "model B stall_id",
                inst == 0 ? int'(a_stall_id) : int'(b_stall_id), exp_stall);
            chk(inst == 0 ? "model A rs1_sel" : "model B rs1_sel",
                inst == 0 ? int'(a_sel1) : int'(b_sel1), s1);
            chk(inst == 0 ? "model A rs2_sel" : "model B rs2_sel",
                inst == 0 ? int'(a_sel2) : int'(b_sel2), s2);
            chk(inst == 0 ? "model A mask" : "model B mask",
                inst == 0 ? int'(a_mask) : int'(b_mask), model_mask(inst));
            chk(inst == 0 ? "model A count" : "model B count",
                inst == 0 ? int'(a_cnt) : int'(b_cnt), mcnt[inst]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                        input logic u2, input logic [3:0] rd, input logic we, input logic ld);
      id_valid    = v;
      id_rs1      = rs1;
      id_uses_rs1 = u1;
      id_rs2      = rs2;
      id_uses_rs2 = u2;
      id_rd       = rd;
      id_we       = we;
      id_is_load  = ld;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      flush     = 1'b0;
      stall_ext = 1'b0;
      repeat (n) cyc();
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      stall_ext = 1'b0;
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

      // Reset state
      cyc();
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("reset stall_id", a_stall_id, 0);
      chk("reset rs1_sel", a_sel1, 0);
      chk("reset rs2_sel", a_sel2, 0);
      chk("reset mask", a_mask, 0);
      chk("reset count", a_cnt, 0);
      chk("reset B count", b_cnt, 0);
      idle(1);

      // ALU dependency at distance 1
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 4'd5, 1'b1, 4'd1, 1'b1, 4'd6, 1'b1, 1'b0);
      @(negedge clk);
      chk("alu stall c1", a_stall_id, 1);
      chk("alu B stall c1", b_stall_id, 1);
      cyc();
      @(negedge clk);
      chk("alu stall c2", a_stall_id, 0);
      chk("alu rs1_sel", a_sel1, 2);
      chk("alu rs2_sel", a_sel2, 0);
      chk("alu count", a_cnt, 1);
      chk("alu B stall c2", b_stall_id, 1);
      cyc();
      idle(6);

      // Load-use
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1);
      cyc();
      drive(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("load stall", a_stall_id, 1);
         cyc();
      end
      @(negedge clk);
      chk("load stall end", a_stall_id, 0);
      chk("load rs1_sel", a_sel1, 4);
      chk("load count", a_cnt, 4);
      cyc();
      idle(6);

      // x0 is never tracked and never hazards
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("x0 stall", a_stall_id, 0);
      chk("x0 rs1_sel", a_sel1, 0);
      chk("x0 rs2_sel", a_sel2, 0);
      chk("x0 mask", a_mask, 0);
      chk("x0 B stall", b_stall_id, 0);
      cyc();
      idle(6);

      // Youngest of duplicate writers wins; rs1==rs2 gives identical selects
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
      cyc();
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("dup stall", a_stall_id, 0);
      chk("dup rs1_sel", a_sel1, 2);
      chk("dup rs2_sel", a_sel2, 2);
      chk("dup mask", a_mask, 16'h0180);
      cyc();
      idle(6);

      // External freeze with a hazard pending, then flush during a hazard
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 4'd11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      stall_ext = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("freeze stall", a_stall_id, 1);
         chk("freeze count", a_cnt, 4);
         chk("freeze mask", a_mask, 16'h0800);
         cyc();
      end
      stall_ext = 1'b0;
      @(negedge clk);
      chk("unfreeze stall", a_stall_id, 1);
      chk("unfreeze rs1_sel", a_sel1, 0);
      cyc();
      @(negedge clk);
      chk("unfreeze fwd stall", a_stall_id, 0);
      chk("unfreeze fwd rs1_sel", a_sel1, 2);
      chk("unfreeze count", a_cnt, 5);
      cyc();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 4'd12, 1'b1, 4'd0, 1'b0, 4'd13, 1'b1, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      chk("flush stall", a_stall_id, 0);
      cyc();
      idle(0);
      @(negedge clk);
      chk("flush mask", a_mask, 16'h1000);
      chk("flush count", a_cnt, 5);
      cyc();
      idle(6);

      // No forwarding: stall until the writer leaves WB; 2-bit counter saturates
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("nofwd stall", b_stall_id, 1);
         chk("nofwd sel during stall", b_sel1, 0);
         cyc();
      end
      @(negedge clk);
      chk("nofwd stall end", b_stall_id, 0);
      chk("nofwd rs1_sel", b_sel1, 0);
      chk("nofwd count saturated", b_cnt, 3);
      cyc();
      idle(6);

      // Reset in mid-operation clears entries and counters
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0);
      cyc();
      idle(0);
      rst = 1'b1;
      @(negedge clk);
      chk("pre-reset mask", a_mask, 16'h4000);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("mid reset mask", a_mask, 0);
      chk("mid reset count", a_cnt, 0);
      chk("mid reset B count", b_cnt, 0);
      cyc();
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
